// File: rtl/ansi_text_cursor_ctrl_if.sv
// ansi_text_cursor_ctrl_if: byte stream from the UART receiver, character-RAM write port
// and cursor status of the text-terminal controller, bundled for one connection.
interface ansi_text_cursor_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        cursor_x;
  logic [7:0]        cursor_y;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;

  // Byte source and RAM/cursor consumer side
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, cursor_addr, busy
  );

  // Terminal controller side
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, cursor_addr, busy
  );
endinterface

// File: rtl/ansi_text_cursor_ctrl.sv
// ansi_text_cursor_ctrl: text-terminal controller between a UART receiver and a VGA
// character buffer. Printable bytes are written at the cursor, CR/LF/BS/DEL move it,
// and a small VT100 CSI subset (cursor moves with counts, home, clear-screen) is decoded.
// Clear-screen sweeps every cell with the blank byte, one cell per cycle.
module ansi_text_cursor_ctrl #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 60,
  parameter int         ADDR_W = 13,
  parameter int         WRAP   = 1,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input logic                    clk,
  input logic                    resetn,
  ansi_text_cursor_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ESC, CSI, CLEAR} state_e;

  localparam logic [7:0]          LAST_COL   = 8'(COLS - 1);
  localparam logic [7:0]          LAST_ROW   = 8'(ROWS - 1);
  localparam logic signed [9:0]   LAST_COL_S = 10'(COLS - 1);
  localparam logic signed [9:0]   LAST_ROW_S = 10'(ROWS - 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(COLS * ROWS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_LBR = 8'h5B;
  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_B   = 8'h42;
  localparam logic [7:0] CH_C   = 8'h43;
  localparam logic [7:0] CH_D   = 8'h44;
  localparam logic [7:0] CH_H   = 8'h48;
  localparam logic [7:0] CH_J   = 8'h4A;

  state_e            state_q, state_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [6:0]        param_q, param_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W-1:0] cursorAddr_q, cursorAddr_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]        wrData_q, wrData_d;

  logic              inClear;
  logic              accept;
  logic [7:0]        rxByte;
  logic              isDigit;
  logic              isPrintable;
  logic [7:0]        rowNext;
  logic [6:0]        moveN;
  logic signed [9:0] colS, rowS, moveS;
  logic signed [9:0] colRight, colLeft, rowUp, rowDown;
  logic [10:0]       paramAcc;

  // Row base address as a constant table lookup, so no multiplier sits behind cursor_addr
  function automatic logic [ADDR_W-1:0] rowBase(input logic [7:0] r);
    logic [ADDR_W-1:0] base;
    base = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r == 8'(i)) base = ADDR_W'(i * COLS);
    end
    return base;
  endfunction

  assign inClear     = (state_q == CLEAR);
  assign accept      = bus.rx_valid & ~inClear;
  assign rxByte      = bus.rx_data;
  assign isDigit     = (rxByte >= 8'h30) && (rxByte <= 8'h39);
  assign isPrintable = (rxByte >= 8'h20) && (rxByte <= 8'h7E);
  assign rowNext     = (row_q == LAST_ROW) ? 8'd0 : row_q + 8'd1;

  // CSI moves: a count of 0 means 1; everything is widened to signed so clamps see the overshoot
  assign moveN    = (param_q == 7'd0) ? 7'd1 : param_q;
  assign colS     = signed'({2'b00, col_q});
  assign rowS     = signed'({2'b00, row_q});
  assign moveS    = signed'({3'b000, moveN});
  assign colRight = colS + moveS;
  assign colLeft  = colS - moveS;
  assign rowUp    = rowS - moveS;
  assign rowDown  = rowS + moveS;

  // param*10 + digit via shifts; the digit is the low nibble of '0'..'9'
  assign paramAcc = {1'b0, param_q, 3'b000} + {3'b000, param_q, 1'b0} + {7'b0000000, rxByte[3:0]};

  // Byte decoder and clear sweep: next state, cursor, parameter and write strobe
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    param_d  = param_q;
    clr_d    = clr_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (isPrintable) begin
            wrEn_d   = 1'b1;
            wrAddr_d = cursorAddr_q;
            wrData_d = rxByte;
            if (col_q != LAST_COL) begin
              col_d = col_q + 8'd1;
            end else if (WRAP != 0) begin
              col_d = 8'd0;
              row_d = rowNext;
            end
          end else begin
            case (rxByte)
              CH_CR:  col_d = 8'd0;
              CH_LF:  row_d = rowNext;
              CH_BS: begin
                if (col_q != 8'd0) col_d = col_q - 8'd1;
              end
              CH_DEL: begin
                if (col_q != 8'd0) begin
                  col_d    = col_q - 8'd1;
                  wrEn_d   = 1'b1;
                  wrAddr_d = cursorAddr_q - ADDR_W'(1);
                  wrData_d = BLANK;
                end
              end
              CH_ESC: state_d = ESC;
              default: ;
            endcase
          end
        end
      end

      ESC: begin
        if (accept) begin
          if (rxByte == CH_LBR) begin
            state_d = CSI;
            param_d = 7'd0;
          end else if (rxByte != CH_ESC) begin
            state_d = IDLE;
          end
        end
      end

      CSI: begin
        if (accept) begin
          if (isDigit) begin
            param_d = (paramAcc > 11'd99) ? 7'd99 : paramAcc[6:0];
          end else begin
            state_d = IDLE;
            case (rxByte)
              CH_A: row_d = (rowUp < 10'sd0) ? 8'd0 : rowUp[7:0];
              CH_B: row_d = (rowDown > LAST_ROW_S) ? LAST_ROW : rowDown[7:0];
              CH_C: col_d = (colRight > LAST_COL_S) ? LAST_COL : colRight[7:0];
              CH_D: col_d = (colLeft < 10'sd0) ? 8'd0 : colLeft[7:0];
              CH_H: begin
                row_d = 8'd0;
                col_d = 8'd0;
              end
              CH_J: begin
                if (param_q == 7'd2) begin
                  state_d = CLEAR;
                  clr_d   = '0;
                end
              end
              CH_ESC: state_d = ESC;
              default: ;
            endcase
          end
        end
      end

      CLEAR: begin
        clr_d = clr_q + ADDR_W'(1);
        if (clr_q == LAST_ADDR) begin
          state_d = IDLE;
          col_d   = 8'd0;
          row_d   = 8'd0;
          clr_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    cursorAddr_d = rowBase(row_d) + ADDR_W'(col_d);
  end

  // State, cursor and write-port registers; reset abandons any sweep immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_q        <= 8'd0;
      row_q        <= 8'd0;
      param_q      <= 7'd0;
      clr_q        <= '0;
      cursorAddr_q <= '0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      param_q      <= param_d;
      clr_q        <= clr_d;
      cursorAddr_q <= cursorAddr_d;
      wrEn_q       <= wrEn_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
    end
  end

  assign bus.rx_ready    = ~inClear;
  assign bus.busy        = inClear;
  assign bus.wr_en       = wrEn_q | inClear;
  assign bus.wr_addr     = inClear ? clr_q : wrAddr_q;
  assign bus.wr_data     = inClear ? BLANK : wrData_q;
  assign bus.cursor_x    = col_q;
  assign bus.cursor_y    = row_q;
  assign bus.cursor_addr = cursorAddr_q;

endmodule

// File: tb/tb_ansi_text_cursor_ctrl.sv
// tb_ansi_text_cursor_ctrl: drives one byte stream into two controllers (WRAP=1 and WRAP=0)
// and compares both against a terminal model that parses escape sequences from a byte buffer.
module tb_ansi_text_cursor_ctrl;

  localparam int         COLS   = 80;
  localparam int         ROWS   = 60;
  localparam int         ADDR_W = 13;
  localparam int         NCELL  = COLS * ROWS;
  localparam logic [7:0] BLANK  = 8'h20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxValid = 1'b0;
  logic [7:0] rxData = 8'h00;

  always #5 clk = ~clk;

  ansi_text_cursor_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();
  ansi_text_cursor_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();

  assign bus1.rx_valid = rxValid;
  assign bus1.rx_data  = rxData;
  assign bus0.rx_valid = rxValid;
  assign bus0.rx_data  = rxData;

  ansi_text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .WRAP(1), .BLANK(BLANK))
    dutWrap (.clk(clk), .resetn(resetn), .bus(bus1));

  ansi_text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .WRAP(0), .BLANK(BLANK))
    dutStick (.clk(clk), .resetn(resetn), .bus(bus0));

  // Reference terminal state, index 1 = wrapping instance, index 0 = sticky instance
  int         mCol [2];
  int         mRow [2];
  logic [7:0] escBuf[$];
  bit         expEn [2];
  int         expAddr [2];
  logic [7:0] expData [2];
  bit         clearStart;
  int         sweepAbortAt = -1;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string      seq;
    bit         en;
    int         addr;
    logic [7:0] wdata;
    int         x;
    int         y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string s, input bit en, input int addr,
                              input logic [7:0] d, input int x, input int y);
    vec_t v;
    v.seq = s; v.en = en; v.addr = addr; v.wdata = d; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mCol[i] = 0; mRow[i] = 0; expEn[i] = 1'b0;
    end
    escBuf.delete();
    clearStart = 1'b0;
  endtask

  task automatic modelPlain(input int i, input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      expEn[i] = 1'b1; expAddr[i] = mRow[i] * COLS + mCol[i]; expData[i] = b;
      if (mCol[i] < COLS - 1) mCol[i]++;
      else if (i == 1) begin
        mCol[i] = 0; mRow[i] = (mRow[i] + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      mCol[i] = 0;
    end else if (b == 8'h0A) begin
      mRow[i] = (mRow[i] + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (mCol[i] > 0) mCol[i]--;
    end else if (b == 8'h7F) begin
      if (mCol[i] > 0) begin
        mCol[i]--;
        expEn[i] = 1'b1; expAddr[i] = mRow[i] * COLS + mCol[i]; expData[i] = BLANK;
      end
    end
  endtask

  task automatic modelCsi(input int i, input logic [7:0] fin, input int p);
    int n;
    n = (p == 0) ? 1 : p;
    case (fin)
      8'h41: mRow[i] = (mRow[i] - n < 0) ? 0 : mRow[i] - n;
      8'h42: mRow[i] = (mRow[i] + n > ROWS - 1) ? ROWS - 1 : mRow[i] + n;
      8'h43: mCol[i] = (mCol[i] + n > COLS - 1) ? COLS - 1 : mCol[i] + n;
      8'h44: mCol[i] = (mCol[i] - n < 0) ? 0 : mCol[i] - n;
      8'h48: begin mRow[i] = 0; mCol[i] = 0; end
      default: ;
    endcase
  endtask

  // The escape buffer holds ESC, '[' and the digits seen so far; a final byte interprets it
  task automatic modelStep(input logic [7:0] b);
    int p;
    clearStart = 1'b0;
    expEn[0] = 1'b0; expEn[1] = 1'b0;
    if (escBuf.size() == 0) begin
      if (b == 8'h1B) escBuf.push_back(b);
      else for (int i = 0; i < 2; i++) modelPlain(i, b);
    end else if (escBuf.size() == 1) begin
      if (b == 8'h5B) escBuf.push_back(b);
      else if (b != 8'h1B) escBuf.delete();
    end else if (b >= 8'h30 && b <= 8'h39) begin
      escBuf.push_back(b);
    end else begin
      p = 0;
      for (int k = 2; k < escBuf.size(); k++) begin
        p = p * 10 + int'(escBuf[k]) - 48;
        if (p > 99) p = 99;
      end
      escBuf.delete();
      for (int i = 0; i < 2; i++) modelCsi(i, b, p);
      if (b == 8'h4A && p == 2) clearStart = 1'b1;
      if (b == 8'h1B) escBuf.push_back(b);
    end
  endtask

  task automatic checkDut(input int i, input string tag, input logic en,
                          input logic [ADDR_W-1:0] addr, input logic [7:0] data,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [ADDR_W-1:0] caddr, input logic busy, input bit expBusy);
    if (expBusy) begin
      checkOutput({tag, ".sweepStart.wr_en"}, int'(en), 1);
      checkOutput({tag, ".sweepStart.wr_addr"}, int'(addr), 0);
      checkOutput({tag, ".sweepStart.wr_data"}, int'(data), int'(BLANK));
    end else begin
      checkOutput({tag, ".wr_en"}, int'(en), int'(expEn[i]));
      if (expEn[i]) begin
        checkOutput({tag, ".wr_addr"}, int'(addr), expAddr[i]);
        checkOutput({tag, ".wr_data"}, int'(data), int'(expData[i]));
      end
    end
    checkOutput({tag, ".cursor_x"}, int'(x), mCol[i]);
    checkOutput({tag, ".cursor_y"}, int'(y), mRow[i]);
    checkOutput({tag, ".cursor_addr"}, int'(caddr), mRow[i] * COLS + mCol[i]);
    checkOutput({tag, ".busy"}, int'(busy), int'(expBusy));
  endtask

  task automatic checkAll(input bit expBusy);
    checkDut(1, "wrap1", bus1.wr_en, bus1.wr_addr, bus1.wr_data, bus1.cursor_x, bus1.cursor_y,
             bus1.cursor_addr, bus1.busy, expBusy);
    checkDut(0, "wrap0", bus0.wr_en, bus0.wr_addr, bus0.wr_data, bus0.cursor_x, bus0.cursor_y,
             bus0.cursor_addr, bus0.busy, expBusy);
  endtask

  // Follows a clear sweep cycle by cycle; optionally pulls reset in the middle of it
  task automatic runSweep(input int abortAt);
    int good;
    int writes;
    good = 0;
    for (int k = 0; k < NCELL; k++) begin
      if (k == abortAt) begin
        checkOutput("sweepBeforeReset", good, abortAt);
        resetn = 1'b0;
        #1;
        modelReset();
        checkAll(1'b0);
        checkOutput("wrap1.rx_ready.inReset", int'(bus1.rx_ready), 1);
        checkOutput("wrap0.rx_ready.inReset", int'(bus0.rx_ready), 1);
        writes = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (bus1.wr_en || bus0.wr_en) writes++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) begin
          @(posedge clk); #1;
          if (bus1.wr_en || bus0.wr_en) writes++;
        end
        checkOutput("writesAfterReset", writes, 0);
        checkOutput("wrap1.rx_ready.afterReset", int'(bus1.rx_ready), 1);
        checkAll(1'b0);
        return;
      end
      if (bus1.wr_en && bus0.wr_en && int'(bus1.wr_addr) == k && int'(bus0.wr_addr) == k &&
          bus1.wr_data == BLANK && bus0.wr_data == BLANK && bus1.busy && bus0.busy &&
          !bus1.rx_ready && !bus0.rx_ready)
        good++;
      @(posedge clk); #1;
    end
    checkOutput("clearSweep", good, NCELL);
    for (int i = 0; i < 2; i++) begin
      mCol[i] = 0; mRow[i] = 0; expEn[i] = 1'b0;
    end
    checkAll(1'b0);
    checkOutput("wrap1.rx_ready.afterSweep", int'(bus1.rx_ready), 1);
  endtask

  // One cycle of stimulus: a byte (valid=1) or an idle cycle, checked #1 after the edge
  task automatic applyStimulus(input bit valid, input logic [7:0] b);
    @(negedge clk);
    if (valid) begin
      checkOutput("wrap1.rx_ready", int'(bus1.rx_ready), 1);
      checkOutput("wrap0.rx_ready", int'(bus0.rx_ready), 1);
    end
    rxValid = valid;
    rxData  = b;
    @(posedge clk); #1;
    rxValid = 1'b0;
    if (valid) modelStep(b);
    else begin
      expEn[0] = 1'b0; expEn[1] = 1'b0; clearStart = 1'b0;
    end
    checkAll(clearStart);
    if (clearStart) runSweep(sweepAbortAt);
  endtask

  function automatic logic [7:0] randByte();
    logic [7:0] ctl [4];
    logic [7:0] fin [6];
    int sel;
    ctl = '{8'h0D, 8'h0A, 8'h08, 8'h7F};
    fin = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h4A};
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: return 8'($urandom_range(32, 126));
      4:          return ctl[$urandom_range(0, 3)];
      5:          return 8'h1B;
      6:          return 8'h5B;
      7:          return 8'($urandom_range(48, 57));
      8:          return fin[$urandom_range(0, 5)];
      default:    return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    string s;

    tbl.push_back(mk("A",                    1, 0,    8'h41, 1,  0));
    tbl.push_back(mk("B",                    1, 1,    8'h42, 2,  0));
    tbl.push_back(mk("\015",                 0, 0,    8'h00, 0,  0));
    tbl.push_back(mk("\012",                 0, 0,    8'h00, 0,  1));
    tbl.push_back(mk("\033[75C",             0, 0,    8'h00, 75, 1));
    tbl.push_back(mk("\033[2B",              0, 0,    8'h00, 75, 3));
    tbl.push_back(mk("\033[12C",             0, 0,    8'h00, 79, 3));
    tbl.push_back(mk("\033[99A",             0, 0,    8'h00, 79, 0));
    tbl.push_back(mk("\033[A",               0, 0,    8'h00, 79, 0));
    tbl.push_back(mk("\033[H",               0, 0,    8'h00, 0,  0));
    tbl.push_back(mk("\033[2B\033[5C",       0, 0,    8'h00, 5,  2));
    tbl.push_back(mk("\177",                 1, 164,  8'h20, 4,  2));
    tbl.push_back(mk("\015\177",             0, 0,    8'h00, 0,  2));
    tbl.push_back(mk("\010",                 0, 0,    8'h00, 0,  2));
    tbl.push_back(mk("\033xQ",               1, 160,  8'h51, 1,  2));
    tbl.push_back(mk("\033[59B\033[9C",      0, 0,    8'h00, 10, 59));
    tbl.push_back(mk("\015\012",             0, 0,    8'h00, 0,  0));
    tbl.push_back(mk("\220\005",             0, 0,    8'h00, 0,  0));
    tbl.push_back(mk("\033[59B\033[123C",    0, 0,    8'h00, 79, 59));
    tbl.push_back(mk("Z",                    1, 4799, 8'h5A, 0,  0));
    tbl.push_back(mk("\033[3\033[2C",        0, 0,    8'h00, 2,  0));
    tbl.push_back(mk("\033[5q",              0, 0,    8'h00, 2,  0));

    $display("[TB] reset");
    modelReset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.rx_ready", int'(bus1.rx_ready), 1);
    checkOutput("reset.wr_en", int'(bus1.wr_en), 0);
    checkOutput("reset.wr_addr", int'(bus1.wr_addr), 0);
    checkOutput("reset.wr_data", int'(bus1.wr_data), 0);
    checkOutput("reset.cursor_x", int'(bus1.cursor_x), 0);
    checkOutput("reset.cursor_y", int'(bus1.cursor_y), 0);
    checkOutput("reset.cursor_addr", int'(bus1.cursor_addr), 0);
    checkOutput("reset.busy", int'(bus1.busy), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] directed vectors");
    for (int n = 0; n < tbl.size(); n++) begin
      v = tbl[n];
      s = v.seq;
      for (int k = 0; k < s.len(); k++) applyStimulus(1'b1, s[k]);
      checkOutput($sformatf("vec%0d.wr_en", n), int'(bus1.wr_en), int'(v.en));
      if (v.en) begin
        checkOutput($sformatf("vec%0d.wr_addr", n), int'(bus1.wr_addr), v.addr);
        checkOutput($sformatf("vec%0d.wr_data", n), int'(bus1.wr_data), int'(v.wdata));
      end
      checkOutput($sformatf("vec%0d.cursor_x", n), int'(bus1.cursor_x), v.x);
      checkOutput($sformatf("vec%0d.cursor_y", n), int'(bus1.cursor_y), v.y);
      checkOutput($sformatf("vec%0d.cursor_addr", n), int'(bus1.cursor_addr), v.y * COLS + v.x);
    end
    checkOutput("sticky.cursor_x", int'(bus0.cursor_x), 79);
    checkOutput("sticky.cursor_y", int'(bus0.cursor_y), 59);

    $display("[TB] full clear sweep");
    s = "\033[7B\033[2J";
    for (int k = 0; k < s.len(); k++) applyStimulus(1'b1, s[k]);
    checkOutput("clear.cursor_x", int'(bus1.cursor_x), 0);
    checkOutput("clear.cursor_y", int'(bus1.cursor_y), 0);
    applyStimulus(1'b1, 8'h4B);

    $display("[TB] clear sweep interrupted by reset");
    sweepAbortAt = 100;
    s = "\033[4C\033[2J";
    for (int k = 0; k < s.len(); k++) applyStimulus(1'b1, s[k]);
    sweepAbortAt = -1;
    applyStimulus(1'b1, 8'h4C);

    $display("[TB] randomized stream");
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, 8'h00);
      else applyStimulus(1'b1, randByte());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
